// File: rtl/midi_voice_allocator.sv
// MIDI note-event voice allocator.
// Takes one MIDI message per accepted event, classifies it as note-on or note-off
// and assigns it to a voice slot: retrigger first, then an idle slot, then steal the oldest.
module midi_voice_allocator #(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    data_ready,
    input  logic [31:0]             MIDI_data,
    output logic                    busy,
    output logic                    event_dropped,
    output logic [8*NUM_VOICES-1:0] voice_pitch,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [NUM_VOICES-1:0]   voice_trigger
);

    localparam int unsigned IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned PITCH_W = 8;
    localparam int unsigned AGE_W   = 8;
    localparam logic [PITCH_W-1:0] IDLE_PITCH = 8'hFF;
    localparam logic [AGE_W-1:0]   AGE_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        UPDATE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ON   = 2'd1,
        OP_OFF  = 2'd2
    } op_e;

    state_e                                 state_q, state_d;
    op_e                                    op_q, op_d;
    logic [IDX_W-1:0]                       tgt_q, tgt_d;
    logic [3:0]                             status_q, status_d;
    logic [PITCH_W-1:0]                     pitch_q, pitch_d;
    logic [7:0]                             vel_q, vel_d;
    logic [NUM_VOICES-1:0][PITCH_W-1:0]     vpitch_q, vpitch_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]       age_q, age_d;
    logic [NUM_VOICES-1:0]                  active_q, active_d;
    logic [NUM_VOICES-1:0]                  trigger_q, trigger_d;
    logic                                   busy_q, busy_d;
    logic                                   dropped_q, dropped_d;

    logic                                   is_on_c;
    logic                                   is_off_c;
    logic                                   match_hit_c;
    logic [IDX_W-1:0]                       match_idx_c;
    logic                                   idle_hit_c;
    logic [IDX_W-1:0]                       idle_idx_c;
    logic [IDX_W-1:0]                       old_idx_c;
    logic [AGE_W-1:0]                       old_age_c;

    // The channel nibble and top byte of MIDI_data carry nothing this block uses.
    logic unused_bits;
    assign unused_bits = ^{MIDI_data[31:24], MIDI_data[19:16]};

    // Message classification from the captured status nibble and velocity.
    always_comb begin
        is_on_c  = (status_q == 4'h9) && (vel_q != 8'd0);
        is_off_c = (status_q == 4'h8) || ((status_q == 4'h9) && (vel_q == 8'd0));
    end

    // Candidate slots: first pitch match, first idle slot, oldest slot (ties to lowest index).
    always_comb begin
        match_hit_c = 1'b0;
        match_idx_c = '0;
        idle_hit_c  = 1'b0;
        idle_idx_c  = '0;
        old_idx_c   = '0;
        old_age_c   = age_q[0];
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!match_hit_c && active_q[i] && (vpitch_q[i] == pitch_q)) begin
                match_hit_c = 1'b1;
                match_idx_c = IDX_W'(i);
            end
            if (!idle_hit_c && !active_q[i]) begin
                idle_hit_c = 1'b1;
                idle_idx_c = IDX_W'(i);
            end
            if (age_q[i] > old_age_c) begin
                old_age_c = age_q[i];
                old_idx_c = IDX_W'(i);
            end
        end
    end

    // Next-state and voice-update logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tgt_d     = tgt_q;
        status_d  = status_q;
        pitch_d   = pitch_q;
        vel_d     = vel_q;
        vpitch_d  = vpitch_q;
        age_d     = age_q;
        active_d  = active_q;
        trigger_d = '0;
        dropped_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_ready) begin
                    status_d = MIDI_data[23:20];
                    pitch_d  = MIDI_data[15:8];
                    vel_d    = MIDI_data[7:0];
                    state_d  = DECODE;
                end
            end

            DECODE: begin
                dropped_d = data_ready;
                if (is_on_c) begin
                    op_d    = OP_ON;
                    tgt_d   = match_hit_c ? match_idx_c : (idle_hit_c ? idle_idx_c : old_idx_c);
                    state_d = UPDATE;
                end else if (is_off_c) begin
                    op_d    = match_hit_c ? OP_OFF : OP_NONE;
                    tgt_d   = match_idx_c;
                    state_d = UPDATE;
                end else begin
                    op_d    = OP_NONE;
                    state_d = IDLE;
                end
            end

            UPDATE: begin
                dropped_d = data_ready;
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    if (op_q == OP_ON) begin
                        if (IDX_W'(i) == tgt_q) begin
                            vpitch_d[i]  = pitch_q;
                            active_d[i]  = 1'b1;
                            age_d[i]     = '0;
                            trigger_d[i] = 1'b1;
                        end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                            age_d[i] = age_q[i] + AGE_W'(1);
                        end
                    end else if ((op_q == OP_OFF) && (IDX_W'(i) == tgt_q)) begin
                        vpitch_d[i] = IDLE_PITCH;
                        active_d[i] = 1'b0;
                        age_d[i]    = '0;
                    end
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any pending event.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            op_q      <= OP_NONE;
            tgt_q     <= '0;
            status_q  <= '0;
            pitch_q   <= '0;
            vel_q     <= '0;
            vpitch_q  <= {NUM_VOICES{IDLE_PITCH}};
            age_q     <= '0;
            active_q  <= '0;
            trigger_q <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tgt_q     <= tgt_d;
            status_q  <= status_d;
            pitch_q   <= pitch_d;
            vel_q     <= vel_d;
            vpitch_q  <= vpitch_d;
            age_q     <= age_d;
            active_q  <= active_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign busy          = busy_q;
    assign event_dropped = dropped_q;
    assign voice_pitch   = vpitch_q;
    assign voice_active  = active_q;
    assign voice_trigger = trigger_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: a slot-level reference model predicts
// voice state after each accepted event; a monitor compares when busy falls.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            data_ready;
    logic [31:0]     MIDI_data;
    logic            busy;
    logic            event_dropped;
    logic [8*NV-1:0] voice_pitch;
    logic [NV-1:0]   voice_active;
    logic [NV-1:0]   voice_trigger;

    typedef struct packed {
        logic [8*NV-1:0] pitch;
        logic [NV-1:0]   active;
        logic [NV-1:0]   trig;
    } exp_t;

    exp_t expq[$];
    int   m_pitch[NV];
    bit   m_act[NV];
    int   m_age[NV];
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    midi_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_ready   (data_ready),
        .MIDI_data    (MIDI_data),
        .busy         (busy),
        .event_dropped(event_dropped),
        .voice_pitch  (voice_pitch),
        .voice_active (voice_active),
        .voice_trigger(voice_trigger)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_pitch[i] = 255;
            m_act[i]   = 1'b0;
            m_age[i]   = 0;
        end
    endfunction

    // Slot rules applied directly to the arrays; returns the voice picture after the event.
    function automatic exp_t model_event(input logic [31:0] d);
        exp_t e;
        int   st  = int'(d[23:20]);
        int   p   = int'(d[15:8]);
        int   v   = int'(d[7:0]);
        int   t   = -1;
        int   best;
        e.trig = '0;
        if (st == 9 && v != 0) begin
            for (int i = 0; i < NV; i++) if (t < 0 && m_act[i] && m_pitch[i] == p) t = i;
            for (int i = 0; i < NV; i++) if (t < 0 && !m_act[i]) t = i;
            if (t < 0) begin
                best = -1;
                for (int i = 0; i < NV; i++) if (m_age[i] > best) begin best = m_age[i]; t = i; end
            end
            for (int i = 0; i < NV; i++)
                if (i != t && m_act[i]) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
            m_pitch[t] = p;
            m_act[t]   = 1'b1;
            m_age[t]   = 0;
            e.trig[t]  = 1'b1;
        end else if (st == 8 || st == 9) begin
            for (int i = 0; i < NV; i++) if (t < 0 && m_act[i] && m_pitch[i] == p) t = i;
            if (t >= 0) begin
                m_pitch[t] = 255;
                m_act[t]   = 1'b0;
                m_age[t]   = 0;
            end
        end
        for (int i = 0; i < NV; i++) begin
            e.pitch[8*i +: 8] = 8'(m_pitch[i]);
            e.active[i]       = m_act[i];
        end
        return e;
    endfunction

    // Wait (bounded) for busy to drop; returns busy cycles observed.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Issue one event from an idle negedge; returns at the negedge where busy is low again.
    task automatic send(input logic [31:0] d, output int n);
        data_ready = 1'b1;
        MIDI_data  = d;
        expq.push_back(model_event(d));
        @(negedge clk);
        data_ready = 1'b0;
        wait_idle(n);
    endtask

    // Monitor: on each busy falling edge, the oldest expectation must match.
    initial begin : monitor
        bit   prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: event completed with no expectation queued");
                    end else begin
                        e = expq.pop_front();
                        check("sb_pitch",   32'(voice_pitch),   32'(e.pitch));
                        check("sb_active",  32'(voice_active),  32'(e.active));
                        check("sb_trigger", 32'(voice_trigger), 32'(e.trig));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stim
        logic [31:0] d;
        int          r;
        logic [3:0]  st;
        logic [7:0]  vel;
        n_rst      = 1'b0;
        data_ready = 1'b0;
        MIDI_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pitch",   32'(voice_pitch),   32'hFFFF_FFFF);
        check("rst_active",  32'(voice_active),  32'h0);
        check("rst_busy",    32'(busy),          32'h0);
        check("rst_trigger", 32'(voice_trigger), 32'h0);
        check("rst_dropped", 32'(event_dropped), 32'h0);
        n_rst = 1'b1;

        // First note-on, offered on the very first edge out of reset.
        send(32'h0090_3C64, cyc);
        check("on_busy_cycles", 32'(cyc),               32'd2);
        check("on_pitch0",      32'(voice_pitch[7:0]),  32'h3C);
        check("on_active",      32'(voice_active),      32'h1);
        check("on_trigger",     32'(voice_trigger),     32'h1);
        @(negedge clk);
        check("on_trigger_pulse", 32'(voice_trigger),   32'h0);

        // Fill all voices, then steal the oldest.
        send(32'h0090_4040, cyc);
        send(32'h0091_4340, cyc);
        send(32'h0092_4840, cyc);
        send(32'h0093_4C40, cyc);
        check("steal_pitch",   32'(voice_pitch),   32'h4843_404C);
        check("steal_trigger", 32'(voice_trigger), 32'h1);

        // Note-off by status 8 and by note-on with zero velocity.
        send(32'h0080_4000, cyc);
        check("off_trigger", 32'(voice_trigger), 32'h0);
        send(32'h0090_4300, cyc);
        check("off_busy_cycles", 32'(cyc),            32'd2);
        check("off_pitch",   32'(voice_pitch),   32'h48FF_FF4C);
        check("off_active",  32'(voice_active),  32'h9);
        check("off_trigger2", 32'(voice_trigger), 32'h0);

        // Unsupported status leaves everything alone.
        send(32'h00B0_1234, cyc);
        check("ign_pitch",   32'(voice_pitch),   32'h48FF_FF4C);
        check("ign_trigger", 32'(voice_trigger), 32'h0);

        // Second data_ready while busy is dropped and lost.
        data_ready = 1'b1;
        MIDI_data  = 32'h0090_3C64;
        expq.push_back(model_event(32'h0090_3C64));
        @(negedge clk);
        MIDI_data = 32'h0090_4500;
        MIDI_data[7:0] = 8'h50;
        @(negedge clk);
        data_ready = 1'b0;
        check("drop_pulse", 32'(event_dropped), 32'h1);
        @(negedge clk);
        check("drop_clear", 32'(event_dropped), 32'h0);
        check("drop_busy",  32'(busy),          32'h0);

        // Reset asserted during DECODE discards the event.
        data_ready = 1'b1;
        MIDI_data  = 32'h0090_3C64;
        @(negedge clk);
        data_ready = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_pitch",   32'(voice_pitch),   32'hFFFF_FFFF);
        check("mid_rst_active",  32'(voice_active),  32'h0);
        check("mid_rst_busy",    32'(busy),          32'h0);
        check("mid_rst_trigger", 32'(voice_trigger), 32'h0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_trigger", 32'(voice_trigger), 32'h0);
            check("post_rst_active",  32'(voice_active),  32'h0);
        end

        // Randomised traffic over a narrow pitch range to force retriggers, offs and steals.
        for (int k = 0; k < 200; k++) begin
            r   = int'($urandom_range(0, 9));
            vel = 8'($urandom_range(1, 127));
            if (r <= 4)      st = 4'h9;
            else if (r == 5) begin st = 4'h9; vel = 8'h00; end
            else if (r <= 8) st = 4'h8;
            else             st = 4'($urandom_range(10, 15));
            d = {8'($urandom), st, 4'($urandom), 8'(8'h3C + $urandom_range(0, 7)), vel};
            send(d, cyc);
        end

        @(negedge clk);
        check("sb_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
